adc_fifo_writer: RTL

//  Producer end of the sample FIFO whose consumer is the pass-through read stage (rd_en driven by FIFO above-half).

---
 rtl/adc_fifo_writer_if.sv | 30 +++
 rtl/adc_fifo_writer.sv | 126 ++++++++++++
 2 files changed

// File: rtl/adc_fifo_writer_if.sv
// ADC sample in / FIFO write port bundle.
// The writer uses the master view; the ADC and FIFO side uses slave.
interface adc_fifo_writer_if #(
   parameter int DATA_WIDTH = 14
);
   logic [DATA_WIDTH-1:0] adc_data;
   logic                  adc_valid;
   logic                  fifo_full;
   logic                  fifo_wr_rst_busy;
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] wr_data;

   modport master (
      input  adc_data,
      input  adc_valid,
      input  fifo_full,
      input  fifo_wr_rst_busy,
      output wr_en,
      output wr_data
   );

   modport slave (
      output adc_data,
      output adc_valid,
      output fifo_full,
      output fifo_wr_rst_busy,
      input  wr_en,
      input  wr_data
   );
endinterface

// File: rtl/adc_fifo_writer.sv
// ADC capture, decimation and FIFO write producer.
// Define ADC_OFFSET_BIN_EN to convert offset-binary ADC codes to two's complement.
module adc_fifo_writer #(
   parameter int DATA_WIDTH     = 14,
   parameter int DECIM_W        = 8,
   parameter int HOLDOFF_CYCLES = 16,
   parameter int OVF_CNT_W      = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic [DECIM_W-1:0]   decim,
   input  logic                 ovf_clear,
   adc_fifo_writer_if.master    bus,
   output logic                 streaming,
   output logic                 overflow_flag,
   output logic [OVF_CNT_W-1:0] overflow_cnt
);

   localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
   localparam logic [HW-1:0] H_LAST = HW'(HOLDOFF_CYCLES - 1);

   typedef enum logic [1:0] {
      HOLD,
      IDLE,
      STREAM
   } state_t;

   state_t                state;
   logic [HW-1:0]         hcnt;
   logic [DECIM_W-1:0]    n_reg;
   logic [DECIM_W-1:0]    dcnt;
   logic [DATA_WIDTH-1:0] s1_data;
   logic                  s1_sel;
   logic [DATA_WIDTH-1:0] fmt;
   logic                  busy;
   logic                  drop;

   assign busy = bus.fifo_wr_rst_busy;
   assign drop = s1_sel && bus.fifo_full && !busy;

`ifdef ADC_OFFSET_BIN_EN
   assign fmt = {~bus.adc_data[DATA_WIDTH-1], bus.adc_data[DATA_WIDTH-2:0]};
`else
   assign fmt = bus.adc_data;
`endif

   // Control FSM, two-stage sample pipeline and overflow accounting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= HOLD;
         hcnt          <= '0;
         n_reg         <= DECIM_W'(1);
         dcnt          <= '0;
         s1_data       <= '0;
         s1_sel        <= 1'b0;
         bus.wr_en     <= 1'b0;
         bus.wr_data   <= '0;
         streaming     <= 1'b0;
         overflow_flag <= 1'b0;
         overflow_cnt  <= '0;
      end else begin
         s1_sel    <= 1'b0;
         bus.wr_en <= 1'b0;
         if (busy) begin
            // FIFO reset in progress: restart holdoff, drop in-flight data
            state     <= HOLD;
            hcnt      <= '0;
            streaming <= 1'b0;
         end else begin
            if (s1_sel && !bus.fifo_full) begin
               bus.wr_en   <= 1'b1;
               bus.wr_data <= s1_data;
            end
            unique case (state)
               HOLD: begin
                  if (hcnt == H_LAST) begin
                     state <= IDLE;
                     hcnt  <= '0;
                  end else begin
                     hcnt <= hcnt + HW'(1);
                  end
               end
               IDLE: begin
                  n_reg <= (decim == '0) ? DECIM_W'(1) : decim;
                  dcnt  <= '0;
                  if (enable) begin
                     state     <= STREAM;
                     streaming <= 1'b1;
                  end
               end
               STREAM: begin
                  if (enable && bus.adc_valid) begin
                     s1_data <= fmt;
                     s1_sel  <= (dcnt == '0);
                     if (dcnt == n_reg - DECIM_W'(1)) begin
                        dcnt <= '0;
                     end else begin
                        dcnt <= dcnt + DECIM_W'(1);
                     end
                  end
                  if (!enable) begin
                     state     <= IDLE;
                     streaming <= 1'b0;
                  end
               end
               default: begin
                  state     <= HOLD;
                  hcnt      <= '0;
                  streaming <= 1'b0;
               end
            endcase
         end
         if (ovf_clear) begin
            overflow_flag <= 1'b0;
            overflow_cnt  <= '0;
         end else if (drop) begin
            overflow_flag <= 1'b1;
            if (overflow_cnt != '1) begin
               overflow_cnt <= overflow_cnt + OVF_CNT_W'(1);
            end
         end
      end
   end

endmodule
